// File: rtl/rank_order_encoder.sv
// Rank-order spike encoder: emits pixel indices from brightest to dimmest level after an
// optional control preamble. All outputs are registered and OUT_VALID holds until OUT_READY.
module rank_order_encoder #(
    parameter int IMAGE_SIZE    = 256,
    parameter int PIXEL_BITS    = 8,
    parameter int MIN_INTENSITY = 1,
    parameter int MAX_SPIKES    = IMAGE_SIZE,
    parameter int RESET_EVENTS  = 2,
    parameter int IDX_W         = $clog2(IMAGE_SIZE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] IMAGE [IMAGE_SIZE],
    input  logic                  NEW_IMAGE,
    input  logic                  ABORT,
    input  logic                  OUT_READY,
    output logic                  OUT_VALID,
    output logic                  OUT_CTRL,
    output logic [IDX_W-1:0]      OUT_INDEX,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [IDX_W:0]        SPIKE_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SCAN,
        S_EMIT,
        S_FINISH
    } state_t;

    localparam logic [IDX_W-1:0]      LAST_PIX = IDX_W'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0] MIN_LVL  = PIXEL_BITS'(MIN_INTENSITY);
    localparam logic [IDX_W:0]        BUDGET   = (IDX_W + 1)'(MAX_SPIKES);
    localparam logic [1:0]            PRE_LEN  = 2'(RESET_EVENTS);

    state_t                state, state_nxt;
    logic [PIXEL_BITS-1:0] intensity, intensity_nxt;
    logic [IDX_W-1:0]      pixel, pixel_nxt;
    logic [1:0]            ctrl_cnt, ctrl_cnt_nxt;
    logic [IDX_W-1:0]      index_nxt;
    logic [IDX_W:0]        spike_cnt_nxt;

    state_t                adv_state;
    logic [PIXEL_BITS-1:0] adv_intensity;
    logic [IDX_W-1:0]      adv_pixel;

    // Step to the next (pixel, level) position; the level never decrements past the floor.
    always_comb begin
        adv_state     = S_SCAN;
        adv_intensity = intensity;
        adv_pixel     = pixel;
        if (pixel != LAST_PIX) begin
            adv_pixel = pixel + 1'b1;
        end else if (intensity == MIN_LVL) begin
            adv_state = S_FINISH;
        end else begin
            adv_intensity = intensity - 1'b1;
            adv_pixel     = '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        intensity_nxt = intensity;
        pixel_nxt     = pixel;
        ctrl_cnt_nxt  = ctrl_cnt;
        index_nxt     = OUT_INDEX;
        spike_cnt_nxt = SPIKE_COUNT;
        if (ABORT && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (NEW_IMAGE && !ABORT) begin
                        intensity_nxt = '1;
                        pixel_nxt     = '0;
                        ctrl_cnt_nxt  = '0;
                        spike_cnt_nxt = '0;
                        if (RESET_EVENTS > 0) begin
                            state_nxt = S_PREAMBLE;
                            index_nxt = '1;
                        end else begin
                            state_nxt = S_SCAN;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (OUT_READY) begin
                        ctrl_cnt_nxt = ctrl_cnt + 1'b1;
                        if (ctrl_cnt_nxt == PRE_LEN) state_nxt = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (IMAGE[pixel] == intensity) begin
                        index_nxt = pixel;
                        state_nxt = S_EMIT;
                    end else begin
                        state_nxt     = adv_state;
                        intensity_nxt = adv_intensity;
                        pixel_nxt     = adv_pixel;
                    end
                end
                S_EMIT: begin
                    if (OUT_READY) begin
                        spike_cnt_nxt = SPIKE_COUNT + 1'b1;
                        if (spike_cnt_nxt == BUDGET) begin
                            state_nxt = S_FINISH;
                        end else begin
                            state_nxt     = adv_state;
                            intensity_nxt = adv_intensity;
                            pixel_nxt     = adv_pixel;
                        end
                    end
                end
                S_FINISH: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            intensity   <= '0;
            pixel       <= '0;
            ctrl_cnt    <= '0;
            OUT_VALID   <= 1'b0;
            OUT_CTRL    <= 1'b0;
            OUT_INDEX   <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            SPIKE_COUNT <= '0;
        end else begin
            state       <= state_nxt;
            intensity   <= intensity_nxt;
            pixel       <= pixel_nxt;
            ctrl_cnt    <= ctrl_cnt_nxt;
            OUT_VALID   <= (state_nxt == S_PREAMBLE) || (state_nxt == S_EMIT);
            OUT_CTRL    <= (state_nxt == S_PREAMBLE);
            OUT_INDEX   <= index_nxt;
            BUSY        <= (state_nxt != S_IDLE);
            DONE        <= (state_nxt == S_FINISH);
            SPIKE_COUNT <= spike_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rank_order_encoder.sv
// Bench for rank_order_encoder: two instances with different floor/budget/preamble settings,
// checked against a level-by-level reference model of the rank-order event sequence.
module tb_rank_order_encoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] image [4];
    logic       new_image [2];
    logic       abort [2];
    logic       rdy [2];
    logic       ov [2];
    logic       oc [2];
    logic [1:0] oi [2];
    logic       bz [2];
    logic       dn [2];
    logic [2:0] sc [2];

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    int q0[$];
    int q1[$];
    int expq[$];
    int exp_spikes;
    int done_n [2];
    int done_cyc [2];
    int last_hs [2];
    bit stall [2];
    logic p_ctrl [2];
    logic [1:0] p_idx [2];

    always #5 CLK = ~CLK;

    rank_order_encoder #(
        .IMAGE_SIZE(4), .PIXEL_BITS(2), .MIN_INTENSITY(0), .MAX_SPIKES(4), .RESET_EVENTS(2)
    ) u0 (
        .CLK(CLK), .RST(RST), .IMAGE(image), .NEW_IMAGE(new_image[0]), .ABORT(abort[0]),
        .OUT_READY(rdy[0]), .OUT_VALID(ov[0]), .OUT_CTRL(oc[0]), .OUT_INDEX(oi[0]),
        .BUSY(bz[0]), .DONE(dn[0]), .SPIKE_COUNT(sc[0])
    );

    rank_order_encoder #(
        .IMAGE_SIZE(4), .PIXEL_BITS(2), .MIN_INTENSITY(1), .MAX_SPIKES(2), .RESET_EVENTS(0)
    ) u1 (
        .CLK(CLK), .RST(RST), .IMAGE(image), .NEW_IMAGE(new_image[1]), .ABORT(abort[1]),
        .OUT_READY(rdy[1]), .OUT_VALID(ov[1]), .OUT_CTRL(oc[1]), .OUT_INDEX(oi[1]),
        .BUSY(bz[1]), .DONE(dn[1]), .SPIKE_COUNT(sc[1])
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Events accepted per instance: -1 for a control event, else the pixel index.
    always @(negedge CLK) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (ov[k] && rdy[k]) begin
                if (k == 0) q0.push_back(oc[k] ? -1 : int'(oi[k]));
                else        q1.push_back(oc[k] ? -1 : int'(oi[k]));
                if (!oc[k]) last_hs[k] = cyc;
            end
            if (dn[k]) begin
                done_n[k]++;
                done_cyc[k] = cyc;
            end
            if (stall[k] && ov[k] && !RST) begin
                check("hold_ctrl", oc[k], p_ctrl[k]);
                check("hold_index", oi[k], p_idx[k]);
            end
            stall[k]  = ov[k] && !rdy[k];
            p_ctrl[k] = oc[k];
            p_idx[k]  = oi[k];
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Reference: preamble, then every level from brightest down to the floor, pixels ascending.
    task automatic build_model(input int mn, input int mx, input int re);
        expq.delete();
        exp_spikes = 0;
        for (int r = 0; r < re; r++) expq.push_back(-1);
        for (int lvl = 3; lvl >= mn; lvl--)
            for (int i = 0; i < 4; i++)
                if (int'(image[i]) == lvl && exp_spikes < mx) begin
                    expq.push_back(i);
                    exp_spikes++;
                end
    endtask

    task automatic start(input int k);
        if (k == 0) q0.delete(); else q1.delete();
        done_n[k] = 0;
        new_image[k] = 1'b1;
        tick();
        new_image[k] = 1'b0;
    endtask

    task automatic finish_check(input int k, input string tag, input int mn, input int mx,
                                input int re, input bit rnd);
        int got;
        for (int n = 0; n < 300 && bz[k]; n++) begin
            rdy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        rdy[k] = 1'b1;
        check({tag, "_timeout"}, bz[k], 0);
        build_model(mn, mx, re);
        got = (k == 0) ? q0.size() : q1.size();
        check({tag, "_len"}, got, expq.size());
        for (int i = 0; i < expq.size() && i < got; i++)
            check({tag, "_event"}, (k == 0) ? q0[i] : q1[i], expq[i]);
        check({tag, "_spikes"}, sc[k], exp_spikes);
        check({tag, "_done"}, done_n[k], 1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 2; k++) begin
            new_image[k] = 1'b0; abort[k] = 1'b0; rdy[k] = 1'b1;
            done_n[k] = 0; done_cyc[k] = 0; last_hs[k] = 0;
        end
        image = '{2'd0, 2'd0, 2'd0, 2'd0};
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", ov[k], 0); check("rst_ctrl", oc[k], 0);
            check("rst_index", oi[k], 0); check("rst_busy", bz[k], 0);
            check("rst_done", dn[k], 0);  check("rst_count", sc[k], 0);
        end
        RST = 1'b0;
        tick();

        // Full ordering down to level 0 with a two-event preamble.
        image = '{2'd1, 2'd3, 2'd0, 2'd3};
        start(0);
        check("t1_first_valid", ov[0], 1);
        check("t1_first_ctrl", oc[0], 1);
        check("t1_first_index", oi[0], 3);
        check("t1_busy", bz[0], 1);
        finish_check(0, "t1", 0, 4, 2, 0);
        check("t1_count", sc[0], 4);

        // Top-K budget of 2 with floor 1; first match at pixel 1 is visible two cycles later.
        start(1);
        check("t2_busy", bz[1], 1);
        check("t2_valid_t1", ov[1], 0);
        tick();
        check("t2_valid_t2", ov[1], 0);
        tick();
        check("t2_valid_t3", ov[1], 1);
        check("t2_index_t3", oi[1], 1);
        finish_check(1, "t2", 1, 2, 0, 0);
        check("t2_done_latency", done_cyc[1] - last_hs[1], 1);
        check("t2_count", sc[1], 2);

        // Random backpressure on the same image.
        start(0);
        finish_check(0, "t3", 0, 4, 2, 1);

        // Empty image: three full levels of scanning, NEW_IMAGE while busy ignored.
        image = '{2'd0, 2'd0, 2'd0, 2'd0};
        start(1);
        n = 0;
        while (!dn[1] && n < 50) begin
            new_image[1] = (n == 4);
            tick();
            n++;
        end
        new_image[1] = 1'b0;
        check("t4_done_cycles", n, 12);
        finish_check(1, "t4", 1, 2, 0, 0);

        // Abort while the second pixel event is held.
        image = '{2'd1, 2'd3, 2'd0, 2'd3};
        start(0);
        for (n = 0; n < 50 && sc[0] != 1; n++) tick();
        rdy[0] = 1'b0;
        for (n = 0; n < 50 && !ov[0]; n++) tick();
        tick();
        check("t5_held_valid", ov[0], 1);
        check("t5_held_ctrl", oc[0], 0);
        check("t5_held_index", oi[0], 3);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        rdy[0] = 1'b1;
        check("t5_valid", ov[0], 0);
        check("t5_busy", bz[0], 0);
        check("t5_count", sc[0], 1);
        tick(); tick();
        check("t5_no_done", done_n[0], 0);
        check("t5_count_frozen", sc[0], 1);
        start(0);
        finish_check(0, "t5_restart", 0, 4, 2, 0);

        // Asynchronous reset in the middle of a scan.
        image = '{2'd0, 2'd0, 2'd0, 2'd0};
        start(1);
        tick(); tick(); tick();
        #2 RST = 1'b1;
        #1;
        check("t6_busy", bz[1], 0);
        check("t6_valid", ov[1], 0);
        check("t6_done", dn[1], 0);
        check("t6_count", sc[1], 0);
        check("t6_index", oi[1], 0);
        tick();
        RST = 1'b0;
        tick(); tick();
        check("t6_idle", bz[1], 0);
        check("t6_no_done", done_n[1], 0);

        // Random images with random backpressure on both configurations.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) image[i] = 2'($urandom_range(0, 3));
            if (it % 2 == 0) begin
                start(0);
                finish_check(0, "rnd0", 0, 4, 2, 1);
            end else begin
                start(1);
                finish_check(1, "rnd1", 1, 2, 0, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
